// File: rtl/kan_span_locator.sv
// Knot-span locator: finds the B-spline knot span of each sample by binary search.
// Build option KAN_SPAN_CLAMP_EN clamps out-of-range samples onto the end spans.
module kan_span_locator #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_KNOTS    = 32,
   parameter int unsigned IDX_WIDTH    = $clog2(NUM_KNOTS),
   parameter int unsigned SEARCH_ITERS = $clog2(NUM_KNOTS - 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  knot_wr_en,
   input  logic [IDX_WIDTH-1:0]  knot_addr,
   input  logic [DATA_WIDTH-1:0] knot_data,
   input  logic [DATA_WIDTH-1:0] in_x,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_x,
   output logic [IDX_WIDTH-1:0]  out_span,
   output logic [DATA_WIDTH-1:0] out_offset,
   output logic [DATA_WIDTH-1:0] out_width,
   output logic                  out_of_range,
   output logic                  out_zero_width,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  cfg_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RANGE  = 3'd1;
   localparam logic [2:0] SEARCH = 3'd2;
   localparam logic [2:0] RESULT = 3'd3;
   localparam logic [2:0] HOLD   = 3'd4;

   localparam logic [IDX_WIDTH:0]   NUM_KNOTS_EXT = (IDX_WIDTH + 1)'(NUM_KNOTS);
   localparam logic [IDX_WIDTH-1:0] LAST_SPAN     = IDX_WIDTH'(NUM_KNOTS - 2);
   localparam logic [IDX_WIDTH-1:0] LAST_KNOT     = IDX_WIDTH'(NUM_KNOTS - 1);
   localparam logic [IDX_WIDTH-1:0] ITER_LAST     = IDX_WIDTH'(SEARCH_ITERS - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ONE       = IDX_WIDTH'(1);

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] knots_q [NUM_KNOTS];
   logic [DATA_WIDTH-1:0] x_q, x_d;
   logic [IDX_WIDTH-1:0]  lo_q, lo_d;
   logic [IDX_WIDTH-1:0]  hi_q, hi_d;
   logic [IDX_WIDTH-1:0]  iter_q, iter_d;
   logic                  oor_q, oor_d;
`ifdef KAN_SPAN_CLAMP_EN
   logic                  oor_high_q, oor_high_d;
`endif

   logic                  wr_ok;
   logic [IDX_WIDTH:0]    mid_sum;
   logic [IDX_WIDTH-1:0]  mid;
   logic [DATA_WIDTH-1:0] k_first, k_last, k_mid, k_lo, k_lo_next;
   logic [IDX_WIDTH-1:0]  res_span;
   logic [DATA_WIDTH-1:0] res_offset, res_width;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);

   // Writes only land while idle so an in-flight search never sees the table change.
   assign wr_ok = knot_wr_en && (state_q == IDLE) && ({1'b0, knot_addr} < NUM_KNOTS_EXT);

   // Upper midpoint: lo moves up on k[mid] <= x, so the search converges on the largest match.
   assign mid_sum   = {1'b0, lo_q} + {1'b0, hi_q} + (IDX_WIDTH + 1)'(1);
   assign mid       = mid_sum[IDX_WIDTH:1];
   assign k_first   = knots_q[0];
   assign k_last    = knots_q[LAST_KNOT];
   assign k_mid     = knots_q[mid];
   assign k_lo      = knots_q[lo_q];
   assign k_lo_next = knots_q[lo_q + IDX_ONE];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      iter_d  = iter_q;
      oor_d   = oor_q;
`ifdef KAN_SPAN_CLAMP_EN
      oor_high_d = oor_high_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = in_x;
               oor_d   = 1'b0;
               state_d = RANGE;
            end
         end
         RANGE: begin
            if ((x_q < k_first) || (x_q > k_last)) begin
               oor_d   = 1'b1;
`ifdef KAN_SPAN_CLAMP_EN
               oor_high_d = (x_q > k_last);
`endif
               state_d = RESULT;
            end else begin
               lo_d    = '0;
               hi_d    = LAST_SPAN;
               iter_d  = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (k_mid <= x_q) begin
               lo_d = mid;
            end else begin
               hi_d = mid - IDX_ONE;
            end
            iter_d = iter_q + IDX_ONE;
            if (iter_q == ITER_LAST) begin
               state_d = RESULT;
            end
         end
         RESULT: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      res_span   = lo_q;
      res_offset = x_q - k_lo;
      res_width  = k_lo_next - k_lo;
      if (oor_q) begin
`ifdef KAN_SPAN_CLAMP_EN
         if (oor_high_q) begin
            res_span   = LAST_SPAN;
            res_width  = k_last - knots_q[LAST_SPAN];
            res_offset = res_width;
         end else begin
            res_span   = '0;
            res_offset = '0;
            res_width  = knots_q[1] - k_first;
         end
`else
         res_span   = '0;
         res_offset = '0;
         res_width  = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         iter_q  <= '0;
         oor_q   <= 1'b0;
`ifdef KAN_SPAN_CLAMP_EN
         oor_high_q <= 1'b0;
`endif
         cfg_err        <= 1'b0;
         out_x          <= '0;
         out_span       <= '0;
         out_offset     <= '0;
         out_width      <= '0;
         out_of_range   <= 1'b0;
         out_zero_width <= 1'b0;
         for (int unsigned i = 0; i < NUM_KNOTS; i++) begin
            knots_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         iter_q  <= iter_d;
         oor_q   <= oor_d;
`ifdef KAN_SPAN_CLAMP_EN
         oor_high_q <= oor_high_d;
`endif
         if (wr_ok) begin
            knots_q[knot_addr] <= knot_data;
         end
         if (knot_wr_en && !wr_ok) begin
            cfg_err <= 1'b1;
         end
         if (state_q == RESULT) begin
            out_x          <= x_q;
            out_span       <= res_span;
            out_offset     <= res_offset;
            out_width      <= res_width;
            out_of_range   <= oor_q;
            out_zero_width <= (res_width == '0);
         end
      end
   end

endmodule

// File: tb/tb_kan_span_locator.sv
// Directed bench for kan_span_locator; each task checks its own feature inline.
// Expectations follow KAN_SPAN_CLAMP_EN when the bench is built with it.
module tb_kan_span_locator;

   logic        clk;
   logic        rst;
   logic        knot_wr_en;
   logic [4:0]  knot_addr;
   logic [31:0] knot_data;
   logic [31:0] in_x;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_x;
   logic [4:0]  out_span;
   logic [31:0] out_offset;
   logic [31:0] out_width;
   logic        out_of_range;
   logic        out_zero_width;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        cfg_err;

   int total = 0;
   int bad   = 0;

   kan_span_locator dut (
      .clk            (clk),
      .rst            (rst),
      .knot_wr_en     (knot_wr_en),
      .knot_addr      (knot_addr),
      .knot_data      (knot_data),
      .in_x           (in_x),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_x          (out_x),
      .out_span       (out_span),
      .out_offset     (out_offset),
      .out_width      (out_width),
      .out_of_range   (out_of_range),
      .out_zero_width (out_zero_width),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .busy           (busy),
      .cfg_err        (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; every task starts and ends just after a negedge.
   task automatic write_knot(input logic [4:0] a, input logic [31:0] d);
      knot_wr_en = 1'b1;
      knot_addr  = a;
      knot_data  = d;
      @(negedge clk);
      knot_wr_en = 1'b0;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 32; i++) begin
         write_knot(5'(i), 32'(16 * i));
      end
   endtask

   // Returns cycles from acceptance to out_valid (cycle 1 follows the accept edge), -1 on timeout.
   task automatic wait_result(output int cycles);
      cycles = 1;
      while (!out_valid && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      if (!out_valid) cycles = -1;
   endtask

   task automatic run_sample(input logic [31:0] x, output int cycles);
      in_x     = x;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(cycles);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
      total++; if ({out_span, out_offset, out_width, out_x} !== '0) begin
         bad++; $display("FAIL rst_outs: got span=%0d off=%0d width=%0d x=%0d want all 0",
                         out_span, out_offset, out_width, out_x);
      end
   endtask

   task automatic test_in_range();
      int cyc;
      load_ramp();
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL load_cfg_err: got %b want 0", cfg_err); end
      run_sample(32'd100, cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL lat100: got %0d want 8", cyc); end
      total++; if (out_span !== 5'd6 || out_offset !== 32'd4 || out_width !== 32'd16) begin
         bad++; $display("FAIL x100: got span=%0d off=%0d width=%0d want 6 4 16", out_span, out_offset, out_width);
      end
      total++; if (out_of_range !== 1'b0 || out_zero_width !== 1'b0 || out_x !== 32'd100) begin
         bad++; $display("FAIL x100_flags: got oor=%b zw=%b x=%0d want 0 0 100", out_of_range, out_zero_width, out_x);
      end
      release_result();
      run_sample(32'd496, cyc);
      total++; if (out_span !== 5'd30 || out_offset !== 32'd16 || out_width !== 32'd16 || out_of_range !== 1'b0) begin
         bad++; $display("FAIL x496: got span=%0d off=%0d width=%0d oor=%b want 30 16 16 0",
                         out_span, out_offset, out_width, out_of_range);
      end
      release_result();
      run_sample(32'd0, cyc);
      total++; if (out_span !== 5'd0 || out_offset !== 32'd0 || out_width !== 32'd16) begin
         bad++; $display("FAIL x0: got span=%0d off=%0d width=%0d want 0 0 16", out_span, out_offset, out_width);
      end
      release_result();
      run_sample(32'd495, cyc);
      total++; if (out_span !== 5'd30 || out_offset !== 32'd15) begin
         bad++; $display("FAIL x495: got span=%0d off=%0d want 30 15", out_span, out_offset);
      end
      release_result();
   endtask

   task automatic test_out_of_range();
      int cyc;
      run_sample(32'd500, cyc);
      total++; if (cyc !== 3) begin bad++; $display("FAIL lat500: got %0d want 3", cyc); end
`ifdef KAN_SPAN_CLAMP_EN
      total++; if (out_of_range !== 1'b1 || out_span !== 5'd30 || out_offset !== 32'd16 || out_width !== 32'd16) begin
         bad++; $display("FAIL x500: got oor=%b span=%0d off=%0d width=%0d want 1 30 16 16",
                         out_of_range, out_span, out_offset, out_width);
      end
`else
      total++; if (out_of_range !== 1'b1 || out_span !== 5'd0 || out_offset !== 32'd0 || out_width !== 32'd0
                   || out_zero_width !== 1'b1) begin
         bad++; $display("FAIL x500: got oor=%b span=%0d off=%0d width=%0d zw=%b want 1 0 0 0 1",
                         out_of_range, out_span, out_offset, out_width, out_zero_width);
      end
`endif
      total++; if (out_x !== 32'd500) begin bad++; $display("FAIL x500_x: got %0d want 500", out_x); end
      release_result();
      // Lift k[0] to 8 so a small sample falls below the table.
      write_knot(5'd0, 32'd8);
      run_sample(32'd3, cyc);
      total++; if (cyc !== 3) begin bad++; $display("FAIL lat3: got %0d want 3", cyc); end
`ifdef KAN_SPAN_CLAMP_EN
      total++; if (out_of_range !== 1'b1 || out_span !== 5'd0 || out_offset !== 32'd0 || out_width !== 32'd8) begin
         bad++; $display("FAIL x3: got oor=%b span=%0d off=%0d width=%0d want 1 0 0 8",
                         out_of_range, out_span, out_offset, out_width);
      end
`else
      total++; if (out_of_range !== 1'b1 || out_span !== 5'd0 || out_offset !== 32'd0 || out_width !== 32'd0) begin
         bad++; $display("FAIL x3: got oor=%b span=%0d off=%0d width=%0d want 1 0 0 0",
                         out_of_range, out_span, out_offset, out_width);
      end
`endif
      release_result();
      write_knot(5'd0, 32'd0);
   endtask

   task automatic test_hold();
      int cyc;
      run_sample(32'd200, cyc);
      total++; if (cyc !== 8) begin bad++; $display("FAIL lat200: got %0d want 8", cyc); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_span !== 5'd12 || out_offset !== 32'd8
             || out_width !== 32'd16 || out_x !== 32'd200) begin
            bad++; $display("FAIL hold%0d: got v=%b rdy=%b span=%0d off=%0d width=%0d x=%0d want 1 0 12 8 16 200",
                            i, out_valid, in_ready, out_span, out_offset, out_width, out_x);
         end
         @(negedge clk);
      end
      release_result();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL hold_exit: got rdy=%b v=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_cfg_err();
      int cyc;
      in_x     = 32'd300;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy300: got %b want 1", busy); end
      write_knot(5'd3, 32'd40);
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
      wait_result(cyc);
      total++; if (cyc < 0 || out_span !== 5'd18 || out_offset !== 32'd12) begin
         bad++; $display("FAIL x300: got cyc=%0d span=%0d off=%0d want span 18 off 12", cyc, out_span, out_offset);
      end
      release_result();
      run_sample(32'd50, cyc);
      total++; if (out_span !== 5'd3 || out_offset !== 32'd2 || out_width !== 32'd16) begin
         bad++; $display("FAIL k3_kept: got span=%0d off=%0d width=%0d want 3 2 16", out_span, out_offset, out_width);
      end
      release_result();
      // Write k[4]=60 on the same edge the sample is accepted; the search must use it.
      knot_wr_en = 1'b1;
      knot_addr  = 5'd4;
      knot_data  = 32'd60;
      in_x       = 32'd62;
      in_valid   = 1'b1;
      @(negedge clk);
      knot_wr_en = 1'b0;
      in_valid   = 1'b0;
      wait_result(cyc);
      total++; if (cyc !== 8 || out_span !== 5'd4 || out_offset !== 32'd2 || out_width !== 32'd20) begin
         bad++; $display("FAIL same_edge: got cyc=%0d span=%0d off=%0d width=%0d want 8 4 2 20",
                         cyc, out_span, out_offset, out_width);
      end
      release_result();
      write_knot(5'd4, 32'd64);
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_sticky: got %b want 1", cfg_err); end
   endtask

   task automatic test_duplicates();
      int cyc;
      write_knot(5'd6, 32'd80);
      run_sample(32'd80, cyc);
      total++; if (out_span !== 5'd6 || out_offset !== 32'd0 || out_width !== 32'd32 || out_zero_width !== 1'b0) begin
         bad++; $display("FAIL dup2: got span=%0d off=%0d width=%0d zw=%b want 6 0 32 0",
                         out_span, out_offset, out_width, out_zero_width);
      end
      release_result();
      write_knot(5'd7, 32'd80);
      run_sample(32'd80, cyc);
      total++; if (out_span !== 5'd7 || out_width !== 32'd48 || out_zero_width !== 1'b0) begin
         bad++; $display("FAIL dup3: got span=%0d width=%0d zw=%b want 7 48 0", out_span, out_width, out_zero_width);
      end
      release_result();
   endtask

   task automatic test_reset_mid_search();
      int cyc;
      in_x     = 32'd100;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 || out_x !== 32'd0) begin
         bad++; $display("FAIL mid_rst: got v=%b busy=%b cfg=%b x=%0d want 0 0 0 0", out_valid, busy, cfg_err, out_x);
      end
      rst = 1'b0;
      run_sample(32'd0, cyc);
      total++; if (cyc !== 8 || out_span !== 5'd30 || out_width !== 32'd0 || out_zero_width !== 1'b1
                   || out_of_range !== 1'b0) begin
         bad++; $display("FAIL zero_tbl: got cyc=%0d span=%0d width=%0d zw=%b oor=%b want 8 30 0 1 0",
                         cyc, out_span, out_width, out_zero_width, out_of_range);
      end
      release_result();
      run_sample(32'd1, cyc);
      total++; if (cyc !== 3 || out_of_range !== 1'b1) begin
         bad++; $display("FAIL zero_tbl_oor: got cyc=%0d oor=%b want 3 1", cyc, out_of_range);
      end
      release_result();
   endtask

   initial begin
      rst        = 1'b1;
      knot_wr_en = 1'b0;
      knot_addr  = '0;
      knot_data  = '0;
      in_x       = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_in_range();
      test_out_of_range();
      test_hold();
      test_cfg_err();
      test_duplicates();
      test_reset_mid_search();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
